alu_ctrl_issue: RTL and testbench

//  Producer side of the ALU op/operand interface. Sits between ID and EX in the pipelined MIPS core.

---
 rtl/alu_ctrl_issue.sv | 169 ++++++++++++++++
 tb/tb_alu_ctrl_issue.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_ctrl_issue.sv
// ID->EX ALU issue stage: decodes opcode/funct to ALUOP, selects In2, registers through a 2-entry skid buffer.
// Optional build macro ALU_CTRL_ILLEGAL_TRAP_EN: flags unsupported encodings on ex_illegal.
module alu_ctrl_issue #(
  parameter int         DATA_W     = 32,
  parameter logic [2:0] DEFAULT_OP = 3'b010
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              id_valid,
  output logic              id_ready,
  input  logic [5:0]        id_opcode,
  input  logic [5:0]        id_funct,
  input  logic [DATA_W-1:0] id_rs_val,
  input  logic [DATA_W-1:0] id_rt_val,
  input  logic [15:0]       id_imm,
  output logic              ex_valid,
  input  logic              ex_ready,
  output logic [2:0]        ex_aluop,
  output logic [DATA_W-1:0] ex_in1,
  output logic [DATA_W-1:0] ex_in2,
  output logic              ex_illegal
);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  localparam logic [1:0] SEL_RT   = 2'b00;
  localparam logic [1:0] SEL_SEXT = 2'b01;
  localparam logic [1:0] SEL_ZEXT = 2'b10;

  typedef struct packed {
    logic [2:0]        aluop;
    logic [DATA_W-1:0] in1;
    logic [DATA_W-1:0] in2;
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
    logic              illegal;
`endif
  } op_t;

  logic [2:0] aluop_s;
  logic [1:0] sel_s;
  op_t        dec_s;
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
  logic       illegal_s;
`endif

  // Instruction decode into ALUOP and In2 source
  always_comb begin
    aluop_s = DEFAULT_OP;
    sel_s   = SEL_RT;
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
    illegal_s = 1'b0;
`endif
    case (id_opcode)
      6'b000000: begin
        case (id_funct)
          6'b100000, 6'b100001: aluop_s = OP_ADD;
          6'b100010, 6'b100011: aluop_s = OP_SUB;
          6'b100100:            aluop_s = OP_AND;
          6'b100101:            aluop_s = OP_OR;
          6'b101010:            aluop_s = OP_SLT;
          default: begin
            aluop_s = DEFAULT_OP;
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
            illegal_s = 1'b1;
`endif
          end
        endcase
      end
      6'b100011, 6'b101011, 6'b001000: begin aluop_s = OP_ADD; sel_s = SEL_SEXT; end
      6'b000100:                       begin aluop_s = OP_SUB; sel_s = SEL_RT;   end
      6'b001010:                       begin aluop_s = OP_SLT; sel_s = SEL_SEXT; end
      6'b001100:                       begin aluop_s = OP_AND; sel_s = SEL_ZEXT; end
      6'b001101:                       begin aluop_s = OP_OR;  sel_s = SEL_ZEXT; end
      default: begin
        aluop_s = DEFAULT_OP;
        sel_s   = SEL_RT;
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
        illegal_s = 1'b1;
`endif
      end
    endcase
  end

  // Assemble the decoded op payload
  always_comb begin
    dec_s       = '0;
    dec_s.aluop = aluop_s;
    dec_s.in1   = id_rs_val;
    case (sel_s)
      SEL_SEXT: dec_s.in2 = {{(DATA_W-16){id_imm[15]}}, id_imm};
      SEL_ZEXT: dec_s.in2 = {{(DATA_W-16){1'b0}}, id_imm};
      default:  dec_s.in2 = id_rt_val;
    endcase
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
    dec_s.illegal = illegal_s;
`endif
  end

  logic or_valid_q, or_valid_d;
  logic sr_valid_q, sr_valid_d;
  op_t  or_q, or_d;
  op_t  sr_q, sr_d;
  logic accept_s;
  logic or_free_s;

  // id_ready depends only on registered state, never on ex_ready
  assign id_ready  = ~sr_valid_q;
  assign accept_s  = id_valid & ~sr_valid_q & ~flush;
  assign or_free_s = ~or_valid_q | ex_ready;

  // Skid-buffer next state: SR has priority over new input when OR frees up
  always_comb begin
    or_valid_d = or_valid_q;
    sr_valid_d = sr_valid_q;
    or_d       = or_q;
    sr_d       = sr_q;
    if (flush) begin
      or_valid_d = 1'b0;
      sr_valid_d = 1'b0;
    end else if (or_free_s) begin
      if (sr_valid_q) begin
        or_d       = sr_q;
        or_valid_d = 1'b1;
        sr_valid_d = 1'b0;
      end else if (accept_s) begin
        or_d       = dec_s;
        or_valid_d = 1'b1;
      end else begin
        or_valid_d = 1'b0;
      end
    end else if (accept_s) begin
      sr_d       = dec_s;
      sr_valid_d = 1'b1;
    end else begin
      sr_valid_d = sr_valid_q;
    end
  end

  // State registers for valid bits and op payloads
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      or_valid_q <= 1'b0;
      sr_valid_q <= 1'b0;
      or_q       <= '{aluop: DEFAULT_OP, default: '0};
      sr_q       <= '{aluop: DEFAULT_OP, default: '0};
    end else begin
      or_valid_q <= or_valid_d;
      sr_valid_q <= sr_valid_d;
      or_q       <= or_d;
      sr_q       <= sr_d;
    end
  end

  assign ex_valid = or_valid_q;
  assign ex_aluop = or_q.aluop;
  assign ex_in1   = or_q.in1;
  assign ex_in2   = or_q.in2;
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
  assign ex_illegal = or_q.illegal;
`else
  assign ex_illegal = 1'b0;
`endif

endmodule

// File: tb/tb_alu_ctrl_issue.sv
// Directed bench for alu_ctrl_issue: decode vector table plus skid-buffer, flush and reset sequences.
module tb_alu_ctrl_issue;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        id_valid;
  logic        id_ready;
  logic [5:0]  id_opcode;
  logic [5:0]  id_funct;
  logic [31:0] id_rs_val;
  logic [31:0] id_rt_val;
  logic [15:0] id_imm;
  logic        ex_valid;
  logic        ex_ready;
  logic [2:0]  ex_aluop;
  logic [31:0] ex_in1;
  logic [31:0] ex_in2;
  logic        ex_illegal;

  int checks;
  int errors;

  alu_ctrl_issue #(.DATA_W(32), .DEFAULT_OP(3'b010)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_opcode(id_opcode), .id_funct(id_funct),
    .id_rs_val(id_rs_val), .id_rt_val(id_rt_val), .id_imm(id_imm),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_aluop(ex_aluop), .ex_in1(ex_in1), .ex_in2(ex_in2),
    .ex_illegal(ex_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [15:0] imm;
    logic [2:0]  e_op;
    logic [31:0] e_in2;
    logic        unsup;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic exp_ill(input logic unsup);
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
    return unsup;
`else
    return 1'b0 & unsup;
`endif
  endfunction

  task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic [31:0] rs,
                       input logic [31:0] rt, input logic [15:0] imm);
    id_valid  = 1'b1;
    id_opcode = op;
    id_funct  = fn;
    id_rs_val = rs;
    id_rt_val = rt;
    id_imm    = imm;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_ex_valid"},   {31'd0, ex_valid},   32'd0);
    chk({tag, "_ex_aluop"},   {29'd0, ex_aluop},   32'd2);
    chk({tag, "_ex_in1"},     ex_in1,              32'd0);
    chk({tag, "_ex_in2"},     ex_in2,              32'd0);
    chk({tag, "_ex_illegal"}, {31'd0, ex_illegal}, 32'd0);
  endtask

  // Fill OR with A (rs=1) and SR with B (rs=2) while EX stalls
  task automatic fill_both(input string tag);
    ex_ready = 1'b0;
    @(negedge clk);
    drive(6'b001000, 6'd0, 32'd1, 32'd0, 16'h0001);
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_A_in_or"}, ex_in1, 32'd1);
    drive(6'b000000, 6'b100000, 32'd2, 32'd2, 16'hFFFF);
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_id_ready_full"}, {31'd0, id_ready}, 32'd0);
    chk({tag, "_A_held"}, ex_in1, 32'd1);
  endtask

  initial begin
    checks = 0; errors = 0;
    rst_n = 1'b0; flush = 1'b0; id_valid = 1'b0; ex_ready = 1'b1;
    id_opcode = 6'd0; id_funct = 6'd0; id_rs_val = 32'd0; id_rt_val = 32'd0; id_imm = 16'd0;

    //            op         fn         rs     rt          imm       e_op    e_in2          unsup
    vecs[0]  = '{6'b001000, 6'd0,      32'd5, 32'd0,      16'hFFFF, 3'b010, 32'hFFFFFFFF, 1'b0};
    vecs[1]  = '{6'b001101, 6'd0,      32'd0, 32'd7,      16'h8001, 3'b001, 32'h00008001, 1'b0};
    vecs[2]  = '{6'b000100, 6'd0,      32'd3, 32'd3,      16'h0010, 3'b110, 32'd3,        1'b0};
    vecs[3]  = '{6'b000000, 6'b100000, 32'd7, 32'd9,      16'hFFFF, 3'b010, 32'd9,        1'b0};
    vecs[4]  = '{6'b000000, 6'b100001, 32'd1, 32'd2,      16'hFFFF, 3'b010, 32'd2,        1'b0};
    vecs[5]  = '{6'b000000, 6'b100011, 32'd10, 32'd4,     16'hFFFF, 3'b110, 32'd4,        1'b0};
    vecs[6]  = '{6'b000000, 6'b100100, 32'd11, 32'hF0,    16'hFFFF, 3'b000, 32'hF0,       1'b0};
    vecs[7]  = '{6'b000000, 6'b100101, 32'd12, 32'h0F,    16'hFFFF, 3'b001, 32'h0F,       1'b0};
    vecs[8]  = '{6'b000000, 6'b101010, 32'd13, 32'h123,   16'hFFFF, 3'b111, 32'h123,      1'b0};
    vecs[9]  = '{6'b100011, 6'd0,      32'd14, 32'hAA,    16'h8000, 3'b010, 32'hFFFF8000, 1'b0};
    vecs[10] = '{6'b101011, 6'd0,      32'd15, 32'hAA,    16'h0004, 3'b010, 32'd4,        1'b0};
    vecs[11] = '{6'b001010, 6'd0,      32'd16, 32'hAA,    16'hFFFE, 3'b111, 32'hFFFFFFFE, 1'b0};
    vecs[12] = '{6'b001100, 6'd0,      32'd17, 32'hAA,    16'hF0F0, 3'b000, 32'h0000F0F0, 1'b0};
    vecs[13] = '{6'b111111, 6'd0,      32'd18, 32'h55,    16'h1234, 3'b010, 32'h55,       1'b1};
    vecs[14] = '{6'b000000, 6'b000000, 32'd19, 32'h66,    16'hFFFF, 3'b010, 32'h66,       1'b1};
    vecs[15] = '{6'b000000, 6'b100010, 32'd20, 32'd1,     16'hFFFF, 3'b110, 32'd1,        1'b0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_reset_state("reset");
    chk("reset_id_ready", {31'd0, id_ready}, 32'd1);

    // Decode table, one op per transfer with EX always ready
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      drive(vecs[i].op, vecs[i].fn, vecs[i].rs, vecs[i].rt, vecs[i].imm);
      @(posedge clk);
      @(negedge clk);
      id_valid = 1'b0;
      chk($sformatf("v%0d_valid", i),   {31'd0, ex_valid},   32'd1);
      chk($sformatf("v%0d_aluop", i),   {29'd0, ex_aluop},   {29'd0, vecs[i].e_op});
      chk($sformatf("v%0d_in1", i),     ex_in1,              vecs[i].rs);
      chk($sformatf("v%0d_in2", i),     ex_in2,              vecs[i].e_in2);
      chk($sformatf("v%0d_illegal", i), {31'd0, ex_illegal}, {31'd0, exp_ill(vecs[i].unsup)});
    end
    @(negedge clk);
    chk("idle_valid", {31'd0, ex_valid}, 32'd0);

    // Backpressure: A in OR, B in SR, C held off; then drain in order
    fill_both("bp");
    drive(6'b001101, 6'd0, 32'd3, 32'd0, 16'h0003);
    @(posedge clk);
    @(negedge clk);
    chk("bp_C_held_ready", {31'd0, id_ready}, 32'd0);
    chk("bp_A_stable_in1", ex_in1, 32'd1);
    chk("bp_A_stable_in2", ex_in2, 32'd1);
    chk("bp_A_stable_op", {29'd0, ex_aluop}, 32'd2);
    ex_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_B_in1", ex_in1, 32'd2);
    chk("bp_B_in2", ex_in2, 32'd2);
    chk("bp_B_valid", {31'd0, ex_valid}, 32'd1);
    chk("bp_ready_back", {31'd0, id_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    id_valid = 1'b0;
    chk("bp_C_in1", ex_in1, 32'd3);
    chk("bp_C_op", {29'd0, ex_aluop}, 32'd1);
    chk("bp_C_in2", ex_in2, 32'd3);
    @(posedge clk);
    @(negedge clk);
    chk("bp_empty", {31'd0, ex_valid}, 32'd0);

    // Flush with both entries full and a new op offered
    fill_both("fl");
    flush = 1'b1;
    drive(6'b001000, 6'd0, 32'd9, 32'd0, 16'h0009);
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    id_valid = 1'b0;
    ex_ready = 1'b1;
    chk("fl_valid", {31'd0, ex_valid}, 32'd0);
    chk("fl_id_ready", {31'd0, id_ready}, 32'd1);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("fl_quiet%0d", k), {31'd0, ex_valid}, 32'd0);
    end

    // Asynchronous reset in the middle of a stall
    fill_both("rs");
    id_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_state("rs_async");
    chk("rs_async_id_ready", {31'd0, id_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    ex_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("rs_quiet%0d", k), {31'd0, ex_valid}, 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
